bin_to_bcd_seq: RTL and testbench

Iterative, parametrised binary-to-BCD converter that runs the shift/add-3 (double-dabble) algorithm over `BIN_W` clock cycles. It replaces the fixed combinational add-3 cell array with one digit-correction stage per BCD digit, reused every cycle. It sits between the RNG value register and the seven-segment display driver, with a start/ready/done handshake.

---
 rtl/bin_to_bcd_seq.sv | 115 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble). Each SHIFT cycle applies
// the add-3 correction to every digit and shifts in one bit of the input.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int ACC_W = 4 * DIGITS;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [BIN_W-1:0]   bin_sr;
  logic [ACC_W-1:0]   acc;
  logic               ovf_acc;
  logic [CNT_W-1:0]   cnt;

  logic [ACC_W-1:0]   acc_corr;
  logic [ACC_W+BIN_W:0] shifted;
  logic [ACC_W-1:0]   acc_shift;
  logic [BIN_W-1:0]   bin_shift;
  logic               carry_out;
  logic               last_iter;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_iter) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready     = (state == IDLE);
    last_iter = (cnt == CNT_W'(1));
  end

  // One correction stage per digit, reused on every iteration.
  always_comb begin
    acc_corr = acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) begin
        acc_corr[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
    end
  end

  // Padding bit keeps the slices legal when BIN_W is 1.
  always_comb begin
    shifted   = {acc_corr, bin_sr, 1'b0};
    carry_out = shifted[ACC_W+BIN_W];
    acc_shift = shifted[ACC_W+BIN_W-1 -: ACC_W];
    bin_shift = shifted[BIN_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_sr   <= '0;
      acc      <= '0;
      ovf_acc  <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            bin_sr  <= bin_in;
            acc     <= '0;
            ovf_acc <= 1'b0;
            cnt     <= CNT_W'(BIN_W);
          end
        end
        SHIFT: begin
          bin_sr  <= bin_shift;
          acc     <= acc_shift;
          ovf_acc <= ovf_acc | carry_out;
          cnt     <= cnt - CNT_W'(1);
          if (last_iter) begin
            bcd_out  <= acc_shift;
            overflow <= ovf_acc | carry_out;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: three instances (8b/3 digits, 8b/2 digits,
// 16b/5 digits) driven by a vector table plus hand-written sequences.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start8, start2, start16;
  logic [7:0]  bin8, bin2;
  logic [15:0] bin16;
  logic        ready8, ready2, ready16;
  logic        done8, done2, done16;
  logic [11:0] bcd8;
  logic [7:0]  bcd2;
  logic [19:0] bcd16;
  logic        ovf8, ovf2, ovf16;

  int passed = 0;
  int total  = 0;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u8 (
    .clk(clk), .reset(reset), .start(start8), .bin_in(bin8),
    .ready(ready8), .done(done8), .bcd_out(bcd8), .overflow(ovf8)
  );

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u2 (
    .clk(clk), .reset(reset), .start(start2), .bin_in(bin2),
    .ready(ready2), .done(done2), .bcd_out(bcd2), .overflow(ovf2)
  );

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) u16 (
    .clk(clk), .reset(reset), .start(start16), .bin_in(bin16),
    .ready(ready16), .done(done16), .bcd_out(bcd16), .overflow(ovf16)
  );

  typedef struct {
    int          sel;
    logic [15:0] value;
    logic [19:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[16];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic getOut(input int sel, output logic rdy, output logic dn,
                        output logic [19:0] bcd, output logic ov);
    case (sel)
      0:       begin rdy = ready8;  dn = done8;  bcd = 20'(bcd8);  ov = ovf8;  end
      1:       begin rdy = ready2;  dn = done2;  bcd = 20'(bcd2);  ov = ovf2;  end
      default: begin rdy = ready16; dn = done16; bcd = bcd16;      ov = ovf16; end
    endcase
  endtask

  task automatic setIn(input int sel, input logic st, input logic [15:0] v);
    case (sel)
      0:       begin start8  = st; bin8  = v[7:0]; end
      1:       begin start2  = st; bin2  = v[7:0]; end
      default: begin start16 = st; bin16 = v;      end
    endcase
  endtask

  // Called just after a rising edge with the selected DUT ready. Returns the
  // number of edges from acceptance to done and how long ready stayed low.
  task automatic applyStimulus(input int sel, input logic [15:0] value,
                               output int lat, output int ready_low,
                               output logic [19:0] bcd, output logic ov);
    logic rdy, dn;
    setIn(sel, 1'b1, value);
    tick();
    setIn(sel, 1'b0, ~value);
    lat = 0;
    ready_low = 0;
    getOut(sel, rdy, dn, bcd, ov);
    while (!dn && lat < 40) begin
      if (!rdy) ready_low++;
      tick();
      lat++;
      getOut(sel, rdy, dn, bcd, ov);
    end
    if (!dn) $display("[TB] FAIL timeout: sel %0d value %0d got no done", sel, value);
  endtask

  function automatic logic [20:0] bcdRef(input int unsigned v, input int nd);
    logic [19:0] b;
    b = '0;
    for (int d = 0; d < nd; d++) begin
      b[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return {v != 0, b};
  endfunction

  initial begin
    int          lat, rlow, pulses, cycles;
    logic [19:0] bcd;
    logic        ov, prev_done, seen_done;
    logic [20:0] ref_val;
    logic [15:0] v;

    vecs[0]  = '{0, 16'd255,   20'h00255, 1'b0};
    vecs[1]  = '{0, 16'd0,     20'h00000, 1'b0};
    vecs[2]  = '{0, 16'd9,     20'h00009, 1'b0};
    vecs[3]  = '{0, 16'd10,    20'h00010, 1'b0};
    vecs[4]  = '{0, 16'd128,   20'h00128, 1'b0};
    vecs[5]  = '{0, 16'd99,    20'h00099, 1'b0};
    vecs[6]  = '{0, 16'd100,   20'h00100, 1'b0};
    vecs[7]  = '{0, 16'd1,     20'h00001, 1'b0};
    vecs[8]  = '{1, 16'd100,   20'h00000, 1'b1};
    vecs[9]  = '{1, 16'd99,    20'h00099, 1'b0};
    vecs[10] = '{1, 16'd255,   20'h00055, 1'b1};
    vecs[11] = '{1, 16'd10,    20'h00010, 1'b0};
    vecs[12] = '{2, 16'd65535, 20'h65535, 1'b0};
    vecs[13] = '{2, 16'd1000,  20'h01000, 1'b0};
    vecs[14] = '{2, 16'd10000, 20'h10000, 1'b0};
    vecs[15] = '{2, 16'd54321, 20'h54321, 1'b0};

    reset = 1'b1;
    start8 = 1'b0; start2 = 1'b0; start16 = 1'b0;
    bin8 = '0; bin2 = '0; bin16 = '0;
    tick();
    tick();
    reset = 1'b0;
    checkOutput("reset_ready", 32'(ready8), 32'd1);
    checkOutput("reset_done", 32'(done8), 32'd0);
    checkOutput("reset_bcd", 32'(bcd8), 32'd0);
    checkOutput("reset_ovf", 32'(ovf8), 32'd0);
    tick();

    // Consecutive table entries start in the previous done cycle.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].sel, vecs[i].value, lat, rlow, bcd, ov);
      checkOutput($sformatf("vec%0d_bcd", i), 32'(bcd), 32'(vecs[i].bcd));
      checkOutput($sformatf("vec%0d_ovf", i), 32'(ov), 32'(vecs[i].ovf));
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), (vecs[i].sel == 2) ? 32'd16 : 32'd8);
      checkOutput($sformatf("vec%0d_ready_low", i), 32'(rlow), (vecs[i].sel == 2) ? 32'd16 : 32'd8);
    end
    tick();
    checkOutput("done_one_cycle", 32'(done16), 32'd0);

    // Second start while busy must be ignored.
    start8 = 1'b1; bin8 = 8'd200;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    start8 = 1'b1; bin8 = 8'd17;
    tick();
    start8 = 1'b0;
    pulses = 0;
    prev_done = 1'b0;
    bcd = '0;
    for (int c = 0; c < 25; c++) begin
      if (done8) begin
        pulses++;
        bcd = 20'(bcd8);
        if (prev_done) $display("[TB] FAIL done_back_to_back: got 1, expected 0");
      end
      prev_done = done8;
      tick();
    end
    checkOutput("busy_bcd", 32'(bcd), 32'h200);
    checkOutput("busy_pulses", 32'(pulses), 32'd1);
    checkOutput("busy_bcd_held", 32'(bcd8), 32'h200);

    // Reset on cycle 4 of a conversion abandons it.
    start8 = 1'b1; bin8 = 8'd255;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("abort_ready", 32'(ready8), 32'd1);
    checkOutput("abort_bcd", 32'(bcd8), 32'd0);
    checkOutput("abort_ovf", 32'(ovf8), 32'd0);
    seen_done = 1'b0;
    for (cycles = 0; cycles < 12; cycles++) begin
      if (done8) seen_done = 1'b1;
      tick();
    end
    checkOutput("abort_no_done", 32'(seen_done), 32'd0);
    applyStimulus(0, 16'd42, lat, rlow, bcd, ov);
    checkOutput("after_abort_bcd", 32'(bcd), 32'h042);
    checkOutput("after_abort_ovf", 32'(ov), 32'd0);

    // Strided sweep of the 16-bit instance against the decimal model.
    for (int i = 0; i < 256; i++) begin
      v = 16'(i * 257);
      ref_val = bcdRef(32'(v), 5);
      applyStimulus(2, v, lat, rlow, bcd, ov);
      checkOutput($sformatf("sweep_%0d_bcd", v), 32'(bcd), 32'(ref_val[19:0]));
      checkOutput($sformatf("sweep_%0d_ovf", v), 32'(ov), 32'(ref_val[20]));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
